// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Keeps a PC register that drives a 1-cycle synchronous instruction RAM,
// tracks at most one outstanding read, and buffers returned halfword
// instructions in a 2-entry FIFO so decode can stall without losing data.
// A taken branch flushes the buffer and the in-flight read and restarts
// fetching at the (halfword aligned) branch target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        decode_ready_i,
  input  logic [15:0] instruction_i,
  output logic [31:0] instruction_addr_o,
  output logic [15:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  // Bit 0 of every fetch address is forced low: instructions are halfwords.
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h1;

  // Architectural state
  logic [31:0] pc_q,      pc_d;
  logic        req_q,     req_d;
  logic [31:0] req_pc_q,  req_pc_d;
  logic [1:0]  count_q,   count_d;
  logic        rd_ptr_q,  rd_ptr_d;
  logic        wr_ptr_q,  wr_ptr_d;
  logic [15:0] fifo_ins_q [2];
  logic [31:0] fifo_pc_q  [2];

  // Handshake terms shared by the next-state logic
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  // Decide this cycle's pop, push and issue. The issue rule counts the entry
  // already in flight, so the FIFO can never be asked to hold a third entry.
  always_comb begin
    pop       = valid_o && decode_ready_i;
    push      = req_q && !branch_taken_i;
    occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, req_q};
    issue     = !branch_taken_i && (occupancy < 3'd2);
  end

  // Next-state for PC, request tracking and FIFO bookkeeping; a redirect
  // overrides everything else and drops the in-flight response.
  always_comb begin
    pc_d     = pc_q;
    req_d    = 1'b0;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (branch_taken_i) begin
      pc_d     = branch_target_i & ~32'h1;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d     = pc_q + 32'd2;
        req_d    = 1'b1;
        req_pc_d = pc_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q     <= RESET_PC_ALIGNED;
      req_q    <= 1'b0;
      req_pc_q <= 32'h0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // FIFO storage: capture the RAM data together with the PC it was issued for.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fifo_ins_q[0] <= 16'h0;
      fifo_ins_q[1] <= 16'h0;
      fifo_pc_q[0]  <= 32'h0;
      fifo_pc_q[1]  <= 32'h0;
    end else if (push) begin
      fifo_ins_q[wr_ptr_q] <= instruction_i;
      fifo_pc_q[wr_ptr_q]  <= req_pc_q;
    end
  end

  // Outputs: the head entry when the buffer holds something, zeros otherwise.
  always_comb begin
    instruction_addr_o = pc_q;
    valid_o            = (count_q != 2'd0);
    instruction_o      = 16'h0;
    pc_o               = 32'h0;
    if (valid_o) begin
      instruction_o = fifo_ins_q[rd_ptr_q];
      pc_o          = fifo_pc_q[rd_ptr_q];
    end
  end

  // A push into a full buffer means the issue throttling is broken.
  pushIntoFull: assert property (@(posedge clk_i) disable iff (reset_i)
                                 !(push && count_q == 2'd2));

endmodule
